alu_select_sequencer: RTL and testbench

ALU_SELECT_SEQUENCER -- requirements
Module: alu_select_sequencer

---
 rtl/alu_select_sequencer.sv | 109 ++++++++++
 tb/tb_alu_select_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_select_sequencer.sv
// alu_select_sequencer
// Issues one operation at a time to a bank of 16 function units whose outputs
// meet in an external 16:1 one-hot mux. Operands and the one-hot select are
// registered at issue. The sequencer then waits a settle time that depends on
// the opcode: one cycle for opcodes 0-11, and SLOW_CYCLES cycles for 12-15.
// After that it captures the mux output into result and pulses done for one
// cycle. A new request is accepted in the same IDLE cycle that shows done, so
// operations can run back to back with no gap.

module alu_select_sequencer #(
  parameter int bus_size    = 32,
  parameter int SLOW_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          opcode,
  input  logic [bus_size-1:0] a_in,
  input  logic [bus_size-1:0] b_in,
  input  logic [bus_size-1:0] mux_result,
  output logic [15:0]         sel,
  output logic [bus_size-1:0] op_a,
  output logic [bus_size-1:0] op_b,
  output logic                busy,
  output logic [bus_size-1:0] result,
  output logic                done
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Settle length for slow opcodes, truncated to the 4-bit counter width.
  localparam logic [3:0] SLOW_CNT   = 4'(SLOW_CYCLES);
  // First opcode that uses the slow settle time.
  localparam logic [3:0] SLOW_FIRST = 4'd12;

  state_t     state;
  logic [3:0] cnt;

  // Turns an opcode into the one-hot select for the downstream mux.
  function automatic logic [15:0] onehot_sel(input logic [3:0] idx);
    onehot_sel = 16'h0001 << idx;
  endfunction

  // Returns how many cycles to wait for an opcode: 1 for fast, SLOW_CNT for slow.
  function automatic logic [3:0] settle_len(input logic [3:0] idx);
    if (idx >= SLOW_FIRST) begin
      settle_len = SLOW_CNT;
    end else begin
      settle_len = 4'd1;
    end
  endfunction

  // Sequencer state, settle counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      sel    <= 16'h0000;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // done is a single-cycle pulse. Only the capture edge sets it again.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a_in;
            op_b  <= b_in;
            sel   <= onehot_sel(opcode);
            cnt   <= settle_len(opcode);
            busy  <= 1'b1;
            state <= SETTLE;
          end else begin
            // With no request, hold operands, select, result and counter.
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (cnt > 4'd1) begin
            // Wait for the mux path to settle. Inputs are locked out meanwhile.
            cnt <= cnt - 4'd1;
          end else begin
            // The mux output has settled. Capture it and free the sequencer.
            result <= mux_result;
            done   <= 1'b1;
            sel    <= 16'h0000;
            busy   <= 1'b0;
            cnt    <= 4'd0;
            state  <= IDLE;
          end
        end
        default: begin
          // An unreachable encoding falls back to a clean idle state.
          sel   <= 16'h0000;
          busy  <= 1'b0;
          cnt   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_select_sequencer.sv
// Testbench for alu_select_sequencer.
// The bench models the downstream function units and the 16:1 mux, drives
// directed scenarios followed by randomized traffic, and checks each cycle
// against a transaction-level model. Each operation must latch its operands,
// show a one-hot select, settle for its latency, capture, and pulse done.
`timescale 1ns/1ps

module tb_alu_select_sequencer;

  localparam int W = 32;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    opcode;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [W-1:0]  mux_result;
  logic [15:0]   sel;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic [W-1:0]  result;
  logic          done;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_result = '0;
  logic          prev_done = 1'b0;
  bit            fixed_mode = 1'b0;
  logic [W-1:0]  fixed_val = '0;

  alu_select_sequencer #(.bus_size(W), .SLOW_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .a_in(a_in), .b_in(b_in), .mux_result(mux_result),
    .sel(sel), .op_a(op_a), .op_b(op_b), .busy(busy),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural function unit number op.
  function automatic logic [W-1:0] fu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~a;
      6:  return a << b[4:0];
      7:  return a >> b[4:0];
      8:  return b - a;
      9:  return a + 32'd1;
      10: return a * b;
      11: return {a[15:0], b[15:0]};
      12: return ~(a & b);
      13: return ~(a | b);
      14: return a + b + 32'd1;
      15: return {b[15:0], a[15:0]};
      default: return '0;
    endcase
  endfunction

  // Downstream mux: selects the function unit output named by sel.
  always_comb begin
    mux_result = '0;
    if (fixed_mode) begin
      mux_result = fixed_val;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sel[i]) mux_result = fu(i, op_a, op_b);
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advances one clock, then checks that sel is zero or one-hot and that done lasts one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    chk("sel_onehot0", W'($onehot0(sel)), 32'd1);
    chk("done_width", W'(done & prev_done), 32'd0);
    prev_done = done;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, W'(sel), 32'd0);
    chk({tag, "_op_a"}, op_a, 32'd0);
    chk({tag, "_op_b"}, op_b, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_busy"}, W'(busy), 32'd0);
    chk({tag, "_done"}, W'(done), 32'd0);
  endtask

  // Idle cycles with start low and random inputs. Nothing may change.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start  = 1'b0;
      opcode = 4'($urandom);
      a_in   = $urandom;
      b_in   = $urandom;
      step();
      chk("idle_busy", W'(busy), 32'd0);
      chk("idle_sel", W'(sel), 32'd0);
      chk("idle_done", W'(done), 32'd0);
      chk("idle_result", result, exp_result);
    end
  endtask

  // Issues one operation and follows it to completion. With lock set,
  // start stays high with random junk while the operation is busy.
  task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input bit lock);
    int           lat;
    logic [W-1:0] exp;
    logic [15:0]  exp_sel;
    lat     = (op >= 12) ? S : 1;
    exp     = fixed_mode ? fixed_val : fu(op, a, b);
    exp_sel = 16'h0001 << op;
    start   = 1'b1;
    opcode  = 4'(op);
    a_in    = a;
    b_in    = b;
    step();
    chk("issue_sel", W'(sel), W'(exp_sel));
    chk("issue_busy", W'(busy), 32'd1);
    chk("issue_done", W'(done), 32'd0);
    chk("issue_op_a", op_a, a);
    chk("issue_op_b", op_b, b);
    if (lock) begin
      opcode = 4'($urandom);
      a_in   = $urandom;
      b_in   = $urandom;
    end else begin
      start = 1'b0;
    end
    for (int k = 1; k < lat; k++) begin
      step();
      chk("settle_sel", W'(sel), W'(exp_sel));
      chk("settle_busy", W'(busy), 32'd1);
      chk("settle_done", W'(done), 32'd0);
      chk("settle_result", result, exp_result);
      chk("settle_op_a", op_a, a);
    end
    step();
    chk("cap_result", result, exp);
    chk("cap_done", W'(done), 32'd1);
    chk("cap_sel", W'(sel), 32'd0);
    chk("cap_busy", W'(busy), 32'd0);
    chk("cap_op_a", op_a, a);
    chk("cap_op_b", op_b, b);
    exp_result = exp;
    start      = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    opcode = 4'd0;
    a_in   = '0;
    b_in   = '0;
    #2 rst = 1'b1;
    #2;
    chk_all_zero("reset");

    // Edges taken while rst is high must ignore start.
    start  = 1'b1;
    opcode = 4'd3;
    step();
    step();
    chk_all_zero("reset_hold");
    rst = 1'b0;

    // The first issue happens at the first edge after reset falls.
    run_op(1, 32'h0000_0010, 32'h0000_0004, 1'b0);
    idle(2);

    // Fast operation with a fixed mux value.
    fixed_mode = 1'b1;
    fixed_val  = 32'h4400_4400;
    run_op(10, 32'h0000_0005, 32'h0000_0003, 1'b0);
    fixed_mode = 1'b0;
    idle(2);

    // Slow operation.
    run_op(15, $urandom, $urandom, 1'b0);
    idle(1);

    // Busy lockout, followed by back-to-back issues during the done cycle.
    run_op(13, $urandom, $urandom, 1'b1);
    run_op(2, $urandom, $urandom, 1'b1);
    run_op(0, $urandom, $urandom, 1'b0);
    idle(1);

    // Reset in the middle of a slow operation.
    start  = 1'b1;
    opcode = 4'd14;
    a_in   = $urandom;
    b_in   = $urandom;
    step();
    start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midop_reset");
    #1 rst = 1'b0;
    exp_result = '0;
    idle(6);
    run_op(14, $urandom, $urandom, 1'b0);

    // Randomized traffic: random opcodes, lockout junk and idle gaps.
    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(15, 0)), $urandom, $urandom, bit'($urandom_range(1, 0)));
      idle(int'($urandom_range(2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
